count_sequencer: RTL and testbench
==================================

// Module: count_sequencer
// PURPOSE
//  Game-state controller for the scoreboard: consumes one-cycle umpire event pulses and sequences ball/strike/out/inning counts.
//  Owns at-bat end, side-retired and game-over handling, holding the final count on display for a fixed time.
//  Sits between the debounced button front end and the 7-segment/LED display drivers; replaces per-counter reset wiring.
// PARAMETERS
//  MAX_INNING   9   last regulation inning; game ends after the bottom half of this inning
//  HOLD_CYCLES  4   cycles the final count stays displayed in BATTER_END and SIDE_CHANGE (>=1)
//  HW           3   width of hold counter; must satisfy 2**HW > HOLD_CYCLES
// PORTS
//  iCLK           in   1  single clock, all logic rising-edge
//  iRST           in   1  synchronous, active-high reset
//  iNEWGAME       in   1  pulse: restart game (overrides all events)
//  iOUT           in   1  pulse: batter put out (fly/ground)
//  iHIT           in   1  pulse: batter reaches base on hit
//  iSTRIKE        in   1  pulse: called/swinging strike
//  iFOUL          in   1  pulse: foul ball
//  iBALL          in   1  pulse: ball
//  oBALL          out  3  balls 0..4 (4 only during walk hold)
//  oSTRIKE        out  2  strikes 0..3 (3 only during strikeout hold)
//  oOUT           out  2  outs 0..3 (3 only during side-change hold)
//  oINNING        out  4  inning number, 1..MAX_INNING
//  oTOP           out  1  1 = top half, 0 = bottom half
//  oBUSY          out  1  1 when not accepting events (BATTER_END/SIDE_CHANGE/GAME_OVER)
//  oWALK          out  1  one-cycle pulse on ball four
//  oSTRIKEOUT     out  1  one-cycle pulse on strike three
//  oSIDE_RETIRED  out  1  one-cycle pulse on third out
//  oGAME_OVER     out  1  level, high in GAME_OVER
// BEHAVIOUR
//  Reset (iRST=1 at edge): balls=0, strikes=0, outs=0, inning=1, oTOP=1, state=ACCEPT, all pulses 0, oBUSY=0, oGAME_OVER=0.
//  iNEWGAME: next edge same values as reset, from any state; higher priority than every event input.
//  All outputs registered; count change visible the cycle after the event pulse.
//  States: ACCEPT, BATTER_END, SIDE_CHANGE, GAME_OVER.
//  ACCEPT: at most one event per cycle, priority iOUT > iHIT > iSTRIKE > iFOUL > iBALL; lower ones dropped.
//   iSTRIKE: strikes<2 -> strikes+1; strikes==2 -> strikes=3, outs+1, oSTRIKEOUT, -> BATTER_END.
//   iFOUL:   strikes<2 -> strikes+1; strikes==2 -> no change (no out).
//   iBALL:   balls<3 -> balls+1; balls==3 -> balls=4, oWALK, -> BATTER_END.
//   iHIT:    -> BATTER_END, counts unchanged.
//   iOUT:    outs+1, -> BATTER_END.
//   Any transition to BATTER_END loads hold counter with HOLD_CYCLES.
//  BATTER_END: events ignored; counter decrements each cycle; on the cycle it reaches 0:
//   balls=strikes=0; outs==3 -> oSIDE_RETIRED pulse, reload counter, -> SIDE_CHANGE; else -> ACCEPT.
//   So BATTER_END lasts exactly HOLD_CYCLES cycles.
//  SIDE_CHANGE: events ignored; lasts HOLD_CYCLES cycles, then outs=0 and:
//   oTOP=1 -> oTOP=0, -> ACCEPT.
//   oTOP=0 and inning<MAX_INNING -> inning+1, oTOP=1, -> ACCEPT.
//   oTOP=0 and inning==MAX_INNING -> GAME_OVER, counts frozen (outs=0, inning=MAX_INNING, oTOP=0).
//  GAME_OVER: all events ignored; exits only on iRST or iNEWGAME.
//  Pulses are high for exactly the one cycle of the causing transition, and never during iRST/iNEWGAME.
//  Events arriving while oBUSY=1 are lost (front end must not queue).
// STRUCTURE
//  Shared package baseball_defs: state encoding (2-bit localparams), MAX_BALL=4, MAX_STRIKE=3, MAX_OUT=3,
//   event-priority index constants; display drivers reuse the count maxima.
//  One sub-module: hold_timer (load/decrement/zero-flag down counter, width HW).
//  Rest is one FSM plus count registers in this module; no combinational path from inputs to outputs.
// TESTING
//  1. Reset, then 3x iBALL, 2x iSTRIKE -> oBALL=3, oSTRIKE=2, oOUT=0, oBUSY=0, oINNING=1, oTOP=1.
//  2. From 0-2 count, 5x iFOUL then iSTRIKE -> strikes stay 2 through fouls; then oSTRIKE=3,
//     oOUT=1, oSTRIKEOUT for 1 cycle, oBUSY=1 for 4 cycles, then 0-0 count, oBUSY=0.
//  3. iBALL+iSTRIKE+iOUT same cycle at 0-0, 0 outs -> only out taken: oOUT=1, oBALL=0, oSTRIKE=0, BATTER_END.
//  4. Third out in top of inning 1 -> oSIDE_RETIRED after 4 cycles, 4 more cycles of oOUT=3,
//     then oOUT=0, oTOP=0, oINNING=1; an iBALL during hold ignored (oBALL stays 0).
//  5. MAX_INNING=2, drive 12 outs -> oGAME_OVER=1 with oINNING=2, oTOP=0; further events no change;
//     iNEWGAME -> oINNING=1, oTOP=1, oGAME_OVER=0 next cycle.
//  6. iRST asserted mid-BATTER_END (walk hold, oBALL=4) -> next cycle reset values, no oWALK/oSIDE_RETIRED pulse.

Source files
------------

// File: rtl/count_sequencer_pkg.sv
// Shared scoreboard definitions: FSM state encoding, count maxima and
// event-priority indices used by the sequencer and the display drivers.
package baseball_defs;

    localparam logic [1:0] ST_ACCEPT      = 2'd0;
    localparam logic [1:0] ST_BATTER_END  = 2'd1;
    localparam logic [1:0] ST_SIDE_CHANGE = 2'd2;
    localparam logic [1:0] ST_GAME_OVER   = 2'd3;

    typedef enum logic [1:0] {
        ACCEPT      = ST_ACCEPT,
        BATTER_END  = ST_BATTER_END,
        SIDE_CHANGE = ST_SIDE_CHANGE,
        GAME_OVER   = ST_GAME_OVER
    } seqState_t;

    localparam int MAX_BALL   = 4;
    localparam int MAX_STRIKE = 3;
    localparam int MAX_OUT    = 3;

    // Bit positions in the packed event vector; higher index wins.
    localparam int EV_BALL   = 0;
    localparam int EV_FOUL   = 1;
    localparam int EV_STRIKE = 2;
    localparam int EV_HIT    = 3;
    localparam int EV_OUT    = 4;

    function automatic logic [4:0] priorityPick(input logic [4:0] ev);
        logic [4:0] sel;
        sel = '0;
        if (ev[EV_OUT])         sel[EV_OUT]    = 1'b1;
        else if (ev[EV_HIT])    sel[EV_HIT]    = 1'b1;
        else if (ev[EV_STRIKE]) sel[EV_STRIKE] = 1'b1;
        else if (ev[EV_FOUL])   sel[EV_FOUL]   = 1'b1;
        else if (ev[EV_BALL])   sel[EV_BALL]   = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/count_sequencer_hold_timer.sv
// Down counter that holds the display for a fixed number of cycles;
// zero is high on the last cycle of the hold.
module hold_timer #(
    parameter int HW   = 3,
    parameter int LOAD = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [HW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= HW'(LOAD);
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/count_sequencer.sv
// Scoreboard game-state controller: turns umpire event pulses into
// ball/strike/out/inning counts with timed at-bat and side-change holds.
module count_sequencer
    import baseball_defs::*;
#(
    parameter int MAX_INNING  = 9,
    parameter int HOLD_CYCLES = 4,
    parameter int HW          = 3
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iNEWGAME,
    input  logic       iOUT,
    input  logic       iHIT,
    input  logic       iSTRIKE,
    input  logic       iFOUL,
    input  logic       iBALL,
    output logic [2:0] oBALL,
    output logic [1:0] oSTRIKE,
    output logic [1:0] oOUT,
    output logic [3:0] oINNING,
    output logic       oTOP,
    output logic       oBUSY,
    output logic       oWALK,
    output logic       oSTRIKEOUT,
    output logic       oSIDE_RETIRED,
    output logic       oGAME_OVER
);

    localparam logic [3:0] LAST_INNING = 4'(MAX_INNING);

    seqState_t  state, nextState;
    logic [2:0] balls, nextBalls;
    logic [1:0] strikes, nextStrikes;
    logic [1:0] outs, nextOuts;
    logic [3:0] inning, nextInning;
    logic       top, nextTop;
    logic       walk, nextWalk;
    logic       strikeout, nextStrikeout;
    logic       sideRetired, nextSideRetired;
    logic       timerLoad, timerDec, timerZero;
    logic [4:0] evSel;

    // The timer loads HOLD_CYCLES-1 so that zero marks the final hold cycle.
    hold_timer #(
        .HW   (HW),
        .LOAD (HOLD_CYCLES - 1)
    ) uHoldTimer (
        .clock (iCLK),
        .reset (iRST || iNEWGAME),
        .load  (timerLoad),
        .dec   (timerDec),
        .zero  (timerZero)
    );

    assign evSel    = priorityPick({iOUT, iHIT, iSTRIKE, iFOUL, iBALL});
    assign timerDec = (state == BATTER_END) || (state == SIDE_CHANGE);

    always_comb begin
        nextState       = state;
        nextBalls       = balls;
        nextStrikes     = strikes;
        nextOuts        = outs;
        nextInning      = inning;
        nextTop         = top;
        nextWalk        = 1'b0;
        nextStrikeout   = 1'b0;
        nextSideRetired = 1'b0;
        timerLoad       = 1'b0;

        case (state)
            ACCEPT: begin
                if (evSel[EV_OUT]) begin
                    nextOuts  = outs + 2'd1;
                    nextState = BATTER_END;
                    timerLoad = 1'b1;
                end else if (evSel[EV_HIT]) begin
                    nextState = BATTER_END;
                    timerLoad = 1'b1;
                end else if (evSel[EV_STRIKE]) begin
                    if (strikes < 2'(MAX_STRIKE - 1)) begin
                        nextStrikes = strikes + 2'd1;
                    end else begin
                        nextStrikes   = 2'(MAX_STRIKE);
                        nextOuts      = outs + 2'd1;
                        nextStrikeout = 1'b1;
                        nextState     = BATTER_END;
                        timerLoad     = 1'b1;
                    end
                end else if (evSel[EV_FOUL]) begin
                    if (strikes < 2'(MAX_STRIKE - 1))
                        nextStrikes = strikes + 2'd1;
                end else if (evSel[EV_BALL]) begin
                    if (balls < 3'(MAX_BALL - 1)) begin
                        nextBalls = balls + 3'd1;
                    end else begin
                        nextBalls = 3'(MAX_BALL);
                        nextWalk  = 1'b1;
                        nextState = BATTER_END;
                        timerLoad = 1'b1;
                    end
                end
            end

            BATTER_END: begin
                if (timerZero) begin
                    nextBalls   = '0;
                    nextStrikes = '0;
                    if (outs == 2'(MAX_OUT)) begin
                        nextSideRetired = 1'b1;
                        nextState       = SIDE_CHANGE;
                        timerLoad       = 1'b1;
                    end else begin
                        nextState = ACCEPT;
                    end
                end
            end

            SIDE_CHANGE: begin
                if (timerZero) begin
                    nextOuts = '0;
                    if (top) begin
                        nextTop   = 1'b0;
                        nextState = ACCEPT;
                    end else if (inning < LAST_INNING) begin
                        nextInning = inning + 4'd1;
                        nextTop    = 1'b1;
                        nextState  = ACCEPT;
                    end else begin
                        nextState = GAME_OVER;
                    end
                end
            end

            default: ;
        endcase
    end

    // New game shares the reset path so it beats every event input.
    always_ff @(posedge iCLK) begin
        if (iRST || iNEWGAME) begin
            state       <= ACCEPT;
            balls       <= '0;
            strikes     <= '0;
            outs        <= '0;
            inning      <= 4'd1;
            top         <= 1'b1;
            walk        <= 1'b0;
            strikeout   <= 1'b0;
            sideRetired <= 1'b0;
        end else begin
            state       <= nextState;
            balls       <= nextBalls;
            strikes     <= nextStrikes;
            outs        <= nextOuts;
            inning      <= nextInning;
            top         <= nextTop;
            walk        <= nextWalk;
            strikeout   <= nextStrikeout;
            sideRetired <= nextSideRetired;
        end
    end

    assign oBALL         = balls;
    assign oSTRIKE       = strikes;
    assign oOUT          = outs;
    assign oINNING       = inning;
    assign oTOP          = top;
    assign oBUSY         = (state != ACCEPT);
    assign oWALK         = walk;
    assign oSTRIKEOUT    = strikeout;
    assign oSIDE_RETIRED = sideRetired;
    assign oGAME_OVER    = (state == GAME_OVER);

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with MAX_INNING=2 so a full game fits
// in a short run; expected values are hand-computed.
module tb_count_sequencer;

    localparam logic [5:0] NEWGAME = 6'b100000;
    localparam logic [5:0] OUT     = 6'b010000;
    localparam logic [5:0] HIT     = 6'b001000;
    localparam logic [5:0] STRIKE  = 6'b000100;
    localparam logic [5:0] FOUL    = 6'b000010;
    localparam logic [5:0] BALL    = 6'b000001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       newGame = 1'b0, evOut = 1'b0, evHit = 1'b0;
    logic       evStrike = 1'b0, evFoul = 1'b0, evBall = 1'b0;
    logic [2:0] balls;
    logic [1:0] strikes, outs;
    logic [3:0] inning;
    logic       top, busy, walk, strikeout, sideRetired, gameOver;

    int checks = 0;
    int errors = 0;

    count_sequencer #(
        .MAX_INNING  (2),
        .HOLD_CYCLES (4),
        .HW          (3)
    ) dut (
        .iCLK          (clk),
        .iRST          (rst),
        .iNEWGAME      (newGame),
        .iOUT          (evOut),
        .iHIT          (evHit),
        .iSTRIKE       (evStrike),
        .iFOUL         (evFoul),
        .iBALL         (evBall),
        .oBALL         (balls),
        .oSTRIKE       (strikes),
        .oOUT          (outs),
        .oINNING       (inning),
        .oTOP          (top),
        .oBUSY         (busy),
        .oWALK         (walk),
        .oSTRIKEOUT    (strikeout),
        .oSIDE_RETIRED (sideRetired),
        .oGAME_OVER    (gameOver)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge and are sampled on the next one.
    task automatic applyStimulus(input logic [5:0] ev);
        {newGame, evOut, evHit, evStrike, evFoul, evBall} = ev;
        @(posedge clk);
        #1;
        {newGame, evOut, evHit, evStrike, evFoul, evBall} = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checkOutput("rst_balls", 8'(balls), 8'd0);
        checkOutput("rst_strikes", 8'(strikes), 8'd0);
        checkOutput("rst_outs", 8'(outs), 8'd0);
        checkOutput("rst_inning", 8'(inning), 8'd1);
        checkOutput("rst_top", 8'(top), 8'd1);
        checkOutput("rst_busy", 8'(busy), 8'd0);
        checkOutput("rst_gameover", 8'(gameOver), 8'd0);

        $display("[TB] count build-up");
        repeat (3) applyStimulus(BALL);
        repeat (2) applyStimulus(STRIKE);
        checkOutput("t1_balls", 8'(balls), 8'd3);
        checkOutput("t1_strikes", 8'(strikes), 8'd2);
        checkOutput("t1_outs", 8'(outs), 8'd0);
        checkOutput("t1_busy", 8'(busy), 8'd0);
        checkOutput("t1_inning", 8'(inning), 8'd1);
        checkOutput("t1_top", 8'(top), 8'd1);

        $display("[TB] fouls at two strikes, then strikeout");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(FOUL);
            checkOutput("t2_foul_strikes", 8'(strikes), 8'd2);
        end
        applyStimulus(STRIKE);
        checkOutput("t2_strikes", 8'(strikes), 8'd3);
        checkOutput("t2_outs", 8'(outs), 8'd1);
        checkOutput("t2_strikeout", 8'(strikeout), 8'd1);
        checkOutput("t2_busy0", 8'(busy), 8'd1);
        idle(1);
        checkOutput("t2_strikeout_gone", 8'(strikeout), 8'd0);
        checkOutput("t2_busy1", 8'(busy), 8'd1);
        idle(2);
        checkOutput("t2_busy3", 8'(busy), 8'd1);
        checkOutput("t2_hold_strikes", 8'(strikes), 8'd3);
        idle(1);
        checkOutput("t2_busy_end", 8'(busy), 8'd0);
        checkOutput("t2_balls_clr", 8'(balls), 8'd0);
        checkOutput("t2_strikes_clr", 8'(strikes), 8'd0);
        checkOutput("t2_outs_kept", 8'(outs), 8'd1);

        $display("[TB] new game, then simultaneous events");
        applyStimulus(NEWGAME);
        checkOutput("ng_outs", 8'(outs), 8'd0);
        applyStimulus(BALL | STRIKE | OUT);
        checkOutput("t3_outs", 8'(outs), 8'd1);
        checkOutput("t3_balls", 8'(balls), 8'd0);
        checkOutput("t3_strikes", 8'(strikes), 8'd0);
        checkOutput("t3_busy", 8'(busy), 8'd1);
        idle(4);
        checkOutput("t3_busy_end", 8'(busy), 8'd0);

        applyStimulus(FOUL);
        checkOutput("foul_inc", 8'(strikes), 8'd1);
        applyStimulus(HIT | FOUL | BALL);
        checkOutput("hit_busy", 8'(busy), 8'd1);
        checkOutput("hit_strikes", 8'(strikes), 8'd1);
        checkOutput("hit_balls", 8'(balls), 8'd0);
        idle(4);
        checkOutput("hit_clr", 8'(strikes), 8'd0);

        $display("[TB] side retired in top of first");
        applyStimulus(OUT);
        idle(4);
        applyStimulus(OUT);
        checkOutput("t4_outs3", 8'(outs), 8'd3);
        idle(3);
        checkOutput("t4_no_retire_yet", 8'(sideRetired), 8'd0);
        idle(1);
        checkOutput("t4_retired", 8'(sideRetired), 8'd1);
        checkOutput("t4_outs_hold", 8'(outs), 8'd3);
        checkOutput("t4_busy", 8'(busy), 8'd1);
        applyStimulus(BALL);
        checkOutput("t4_ball_ignored", 8'(balls), 8'd0);
        checkOutput("t4_retired_gone", 8'(sideRetired), 8'd0);
        idle(2);
        checkOutput("t4_outs_hold2", 8'(outs), 8'd3);
        idle(1);
        checkOutput("t4_outs_clr", 8'(outs), 8'd0);
        checkOutput("t4_top", 8'(top), 8'd0);
        checkOutput("t4_inning", 8'(inning), 8'd1);
        checkOutput("t4_busy_end", 8'(busy), 8'd0);

        $display("[TB] play out to game over");
        for (int half = 0; half < 3; half++) begin
            for (int o = 0; o < 3; o++) begin
                applyStimulus(OUT);
                idle(4);
            end
            idle(4);
            if (half == 0) begin
                checkOutput("t5_inning_top2", 8'(inning), 8'd2);
                checkOutput("t5_top_top2", 8'(top), 8'd1);
            end else if (half == 1) begin
                checkOutput("t5_inning_bot2", 8'(inning), 8'd2);
                checkOutput("t5_top_bot2", 8'(top), 8'd0);
                checkOutput("t5_gameover_early", 8'(gameOver), 8'd0);
            end
        end
        checkOutput("t5_gameover", 8'(gameOver), 8'd1);
        checkOutput("t5_inning", 8'(inning), 8'd2);
        checkOutput("t5_top", 8'(top), 8'd0);
        checkOutput("t5_outs", 8'(outs), 8'd0);
        checkOutput("t5_busy", 8'(busy), 8'd1);
        applyStimulus(BALL | STRIKE | OUT);
        idle(3);
        checkOutput("t5_frozen_balls", 8'(balls), 8'd0);
        checkOutput("t5_frozen_outs", 8'(outs), 8'd0);
        checkOutput("t5_still_over", 8'(gameOver), 8'd1);
        applyStimulus(NEWGAME | BALL);
        checkOutput("t5_ng_inning", 8'(inning), 8'd1);
        checkOutput("t5_ng_top", 8'(top), 8'd1);
        checkOutput("t5_ng_over", 8'(gameOver), 8'd0);
        checkOutput("t5_ng_balls", 8'(balls), 8'd0);

        $display("[TB] reset during walk hold");
        repeat (3) applyStimulus(BALL);
        applyStimulus(BALL);
        checkOutput("t6_balls4", 8'(balls), 8'd4);
        checkOutput("t6_walk", 8'(walk), 8'd1);
        idle(1);
        checkOutput("t6_walk_gone", 8'(walk), 8'd0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checkOutput("t6_balls", 8'(balls), 8'd0);
        checkOutput("t6_busy", 8'(busy), 8'd0);
        checkOutput("t6_walk_rst", 8'(walk), 8'd0);
        checkOutput("t6_retired_rst", 8'(sideRetired), 8'd0);

        repeat (3) applyStimulus(BALL);
        rst = 1'b1;
        evBall = 1'b1;
        idle(1);
        rst = 1'b0;
        evBall = 1'b0;
        checkOutput("t6_rst_walk_pulse", 8'(walk), 8'd0);
        checkOutput("t6_rst_walk_balls", 8'(balls), 8'd0);
        checkOutput("t6_rst_walk_busy", 8'(busy), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
